// File: rtl/axi_seg_cmd_issue.sv
// Segment command issuer: buffers 4 KB-safe segments in a small FIFO,
// converts each byte count to AXI INCR beats, splits at MAX_BEATS and
// issues the resulting commands on AR (reads) or AW (writes).
//
// Handshake: a command transfers on a rising edge where valid and ready
// are both high; valid is a function of registered state only, never of
// ready, and the payload is held until that transfer happens.
module axi_seg_cmd_issue #(
  parameter int DATA_BYTES = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BEATS  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seg_wr,
  input  logic [77:0] seg_wrdata,
  output logic        seg_full,
  output logic        seg_overflow,
  output logic        seg_err,
  output logic        cmd_busy,
  output logic        arvalid,
  input  logic        arready,
  output logic [63:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int SIZE_W = $clog2(DATA_BYTES);
  localparam logic [PTR_W:0] DEPTH_C    = FIFO_DEPTH[PTR_W:0];
  localparam logic [12:0]    MAX_B      = MAX_BEATS[12:0];
  localparam logic [7:0]     MAX_LEN    = 8'(MAX_BEATS - 1);
  localparam logic [63:0]    ALIGN_MASK = ~64'(DATA_BYTES - 1);
  localparam logic [63:0]    SPLIT_STEP = 64'(MAX_BEATS * DATA_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_ISSUE} state_t;

  state_t            state_q, state_d;
  logic [77:0]       mem_q [FIFO_DEPTH];
  logic [77:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              work_rd_q, work_rd_d, work_wr_q, work_wr_d;
  logic [11:0]       work_bytes_q, work_bytes_d;
  logic [63:0]       cur_addr_q, cur_addr_d;
  logic [12:0]       beats_rem_q, beats_rem_d;
  logic              seg_full_q, seg_full_d, seg_overflow_q, seg_overflow_d;
  logic              seg_err_q, seg_err_d, cmd_busy_q, cmd_busy_d;

  logic              fifo_full, pop, push, hs, entry_bad;
  logic [13:0]       beat_sum;
  logic [7:0]        cmd_len;

  assign fifo_full = (count_q == DEPTH_C);
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign push      = seg_wr && (!fifo_full || pop);
  assign hs        = work_rd_q ? arready : awready;
  assign entry_bad = (work_rd_q == work_wr_q);
  // Offset within the first beat plus the byte count, rounded up to beats.
  assign beat_sum  = 14'(cur_addr_q & 64'(DATA_BYTES - 1)) + 14'(work_bytes_q)
                   + 14'(DATA_BYTES - 1);
  assign cmd_len   = (beats_rem_q > MAX_B) ? MAX_LEN : 8'(beats_rem_q - 13'd1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_CALC;
      ST_CALC:  state_d = (entry_bad || work_bytes_q == 12'd0) ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: if (hs && beats_rem_q <= MAX_B) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command outputs; the channel not in use holds zero payload
  always_comb begin
    arvalid = 1'b0;
    awvalid = 1'b0;
    araddr  = '0;
    arlen   = '0;
    awaddr  = '0;
    awlen   = '0;
    if (state_q == ST_ISSUE) begin
      if (work_rd_q) begin
        arvalid = 1'b1;
        araddr  = cur_addr_q;
        arlen   = cmd_len;
      end else begin
        awvalid = 1'b1;
        awaddr  = cur_addr_q;
        awlen   = cmd_len;
      end
    end
  end

  assign arsize       = 3'(SIZE_W);
  assign awsize       = 3'(SIZE_W);
  assign arburst      = 2'b01;
  assign awburst      = 2'b01;
  assign seg_full     = seg_full_q;
  assign seg_overflow = seg_overflow_q;
  assign seg_err      = seg_err_q;
  assign cmd_busy     = cmd_busy_q;

  // FIFO, working registers, beat splitting and status flags
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    work_rd_d      = work_rd_q;
    work_wr_d      = work_wr_q;
    work_bytes_d   = work_bytes_q;
    cur_addr_d     = cur_addr_q;
    beats_rem_d    = beats_rem_q;
    seg_overflow_d = seg_overflow_q || (seg_wr && fifo_full && !pop);
    seg_err_d      = seg_err_q || ((state_q == ST_CALC) && entry_bad);
    seg_full_d     = fifo_full;
    cmd_busy_d     = (count_q != '0) || (state_q != ST_IDLE);
    if (push) begin
      mem_d[wr_ptr_q] = seg_wrdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      work_rd_d    = mem_q[rd_ptr_q][77];
      work_wr_d    = mem_q[rd_ptr_q][76];
      work_bytes_d = mem_q[rd_ptr_q][75:64];
      cur_addr_d   = mem_q[rd_ptr_q][63:0];
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (state_q == ST_CALC) beats_rem_d = 13'(beat_sum >> SIZE_W);
    // Later pieces of a split start on a beat boundary.
    if (state_q == ST_ISSUE && hs && beats_rem_q > MAX_B) begin
      beats_rem_d = beats_rem_q - MAX_B;
      cur_addr_d  = (cur_addr_q & ALIGN_MASK) + SPLIT_STEP;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      work_rd_q      <= 1'b0;
      work_wr_q      <= 1'b0;
      work_bytes_q   <= '0;
      cur_addr_q     <= '0;
      beats_rem_q    <= '0;
      seg_full_q     <= 1'b0;
      seg_overflow_q <= 1'b0;
      seg_err_q      <= 1'b0;
      cmd_busy_q     <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      work_rd_q      <= work_rd_d;
      work_wr_q      <= work_wr_d;
      work_bytes_q   <= work_bytes_d;
      cur_addr_q     <= cur_addr_d;
      beats_rem_q    <= beats_rem_d;
      seg_full_q     <= seg_full_d;
      seg_overflow_q <= seg_overflow_d;
      seg_err_q      <= seg_err_d;
      cmd_busy_q     <= cmd_busy_d;
    end
  end

endmodule

// File: tb/tb_axi_seg_cmd_issue.sv
// Directed bench for axi_seg_cmd_issue (DATA_BYTES=8, FIFO_DEPTH=4,
// MAX_BEATS=256). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
module tb_axi_seg_cmd_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seg_wr = 1'b0;
  logic [77:0] seg_wrdata = '0;
  logic        seg_full, seg_overflow, seg_err, cmd_busy;
  logic        arvalid, arready = 1'b1;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        awvalid, awready = 1'b1;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  int n_vec = 0;
  int n_err = 0;
  int ar_hs = 0;
  int aw_hs = 0;
  int both_valid = 0;

  axi_seg_cmd_issue #(.DATA_BYTES(8), .FIFO_DEPTH(4), .MAX_BEATS(256)) dut (
    .clk(clk), .reset(reset), .seg_wr(seg_wr), .seg_wrdata(seg_wrdata),
    .seg_full(seg_full), .seg_overflow(seg_overflow), .seg_err(seg_err),
    .cmd_busy(cmd_busy),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst)
  );

  // Clock
  always #5 clk = ~clk;

  // Handshake and exclusivity monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid && arready) ar_hs++;
      if (awvalid && awready) aw_hs++;
      if (arvalid && awvalid) both_valid++;
    end
  end

  task automatic push(input logic rd, input logic wr, input logic [11:0] bytes,
                      input logic [63:0] addr);
    @(posedge clk); #1;
    seg_wr = 1'b1;
    seg_wrdata = {rd, wr, bytes, addr};
    @(posedge clk); #1;
    seg_wr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for an AR transfer and compare its payload.
  task automatic expect_ar(input string name, input logic [63:0] e_addr,
                           input logic [7:0] e_len, output int waited);
    waited = 0;
    @(negedge clk);
    while (!(arvalid && arready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (!(arvalid && arready)) begin
      n_err++;
      $display("FAIL %s: no AR handshake within 200 cycles", name);
    end else if (araddr !== e_addr || arlen !== e_len) begin
      n_err++;
      $display("FAIL %s: got addr %h len %0d, need addr %h len %0d",
               name, araddr, arlen, e_addr, e_len);
    end
  endtask

  task automatic expect_aw(input string name, input logic [63:0] e_addr,
                           input logic [7:0] e_len, output int waited);
    waited = 0;
    @(negedge clk);
    while (!(awvalid && awready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (!(awvalid && awready)) begin
      n_err++;
      $display("FAIL %s: no AW handshake within 200 cycles", name);
    end else if (awaddr !== e_addr || awlen !== e_len) begin
      n_err++;
      $display("FAIL %s: got addr %h len %0d, need addr %h len %0d",
               name, awaddr, awlen, e_addr, e_len);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({arvalid, awvalid, seg_full, seg_overflow, seg_err, cmd_busy} !== 6'b0 ||
        araddr !== 64'h0 || awaddr !== 64'h0 || arlen !== 8'h0 || awlen !== 8'h0) begin
      n_err++;
      $display("FAIL reset_outputs: valids/flags %b addr %h/%h, need all zero",
               {arvalid, awvalid, seg_full, seg_overflow, seg_err, cmd_busy}, araddr, awaddr);
    end
    n_vec++;
    if (arsize !== 3'd3 || awsize !== 3'd3 || arburst !== 2'b01 || awburst !== 2'b01) begin
      n_err++;
      $display("FAIL reset_constants: size %0d/%0d burst %0d/%0d, need 3/3 1/1",
               arsize, awsize, arburst, awburst);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int w;
    arready = 1'b1;
    push(1'b1, 1'b0, 12'd64, 64'h1000);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_latency_early: arvalid %b one cycle after push, need 0", arvalid);
    end
    expect_ar("rd_single", 64'h1000, 8'd7, w);
    n_vec++;
    if (w !== 0) begin
      n_err++;
      $display("FAIL rd_latency: arvalid came %0d cycles late, need 0", w);
    end
    @(negedge clk);
    n_vec++;
    if (arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_single_done: arvalid %b after handshake, need 0", arvalid);
    end
  endtask

  task automatic test_single_write();
    int w;
    int ar_before;
    ar_before = ar_hs;
    awready = 1'b1;
    push(1'b0, 1'b1, 12'd16, 64'h1003);
    expect_aw("wr_single", 64'h1003, 8'd2, w);
    idle_cycles(3);
    n_vec++;
    if (ar_hs !== ar_before || arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL wr_no_ar: %0d AR transfers during write, need 0", ar_hs - ar_before);
    end
  endtask

  task automatic test_split_read();
    int w1, w2;
    arready = 1'b1;
    push(1'b1, 1'b0, 12'd4092, 64'h3004);
    expect_ar("split_first", 64'h3004, 8'd255, w1);
    expect_ar("split_second", 64'h3800, 8'd255, w2);
    n_vec++;
    if (w2 !== 0) begin
      n_err++;
      $display("FAIL split_continuous: gap %0d cycles between pieces, need 0", w2);
    end
    @(negedge clk);
    n_vec++;
    if (arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL split_done: arvalid %b after second piece, need 0", arvalid);
    end
  endtask

  task automatic test_backpressure();
    int w;
    int stable_bad;
    stable_bad = 0;
    awready = 1'b0;
    push(1'b0, 1'b1, 12'd40, 64'h2008);
    w = 0;
    @(negedge clk);
    while (!awvalid && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 10; i++) begin
      if (awvalid !== 1'b1 || awaddr !== 64'h2008 || awlen !== 8'd4) stable_bad++;
      if (i < 9) @(negedge clk);
    end
    n_vec++;
    if (stable_bad !== 0) begin
      n_err++;
      $display("FAIL bp_stable: %0d unstable cycles while stalled, need 0", stable_bad);
    end
    @(posedge clk); #1;
    awready = 1'b1;
    expect_aw("bp_release", 64'h2008, 8'd4, w);
    n_vec++;
    if (w !== 0) begin
      n_err++;
      $display("FAIL bp_handshake: transfer %0d cycles after ready rose, need 0", w);
    end
  endtask

  task automatic test_overflow();
    int w;
    arready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seg_wr = 1'b1;
      seg_wrdata = {1'b1, 1'b0, 12'd8, 64'(i * 'h100)};
    end
    @(posedge clk); #1;
    seg_wr = 1'b0;
    idle_cycles(2);
    n_vec++;
    if (seg_full !== 1'b1 || seg_overflow !== 1'b1 || cmd_busy !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flags: full %b overflow %b busy %b, need 1 1 1",
               seg_full, seg_overflow, cmd_busy);
    end
    @(posedge clk); #1;
    arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_ar($sformatf("ovf_order_%0d", i), 64'(i * 'h100), 8'd0, w);
    end
    idle_cycles(10);
    n_vec++;
    if (arvalid !== 1'b0 || seg_full !== 1'b0 || cmd_busy !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_drain: arvalid %b full %b busy %b after drain, need 0 0 0",
               arvalid, seg_full, cmd_busy);
    end
  endtask

  task automatic test_zero_and_invalid();
    int ar_before, aw_before;
    arready = 1'b1;
    awready = 1'b1;
    ar_before = ar_hs;
    aw_before = aw_hs;
    push(1'b1, 1'b0, 12'd0, 64'h4000);
    idle_cycles(8);
    n_vec++;
    if (ar_hs !== ar_before || seg_err !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len: %0d commands seg_err %b, need 0 commands err 0",
               ar_hs - ar_before, seg_err);
    end
    push(1'b1, 1'b1, 12'd64, 64'h5000);
    idle_cycles(8);
    n_vec++;
    if (ar_hs !== ar_before || aw_hs !== aw_before || seg_err !== 1'b1) begin
      n_err++;
      $display("FAIL invalid_entry: %0d/%0d commands seg_err %b, need 0/0 err 1",
               ar_hs - ar_before, aw_hs - aw_before, seg_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    int ar_before;
    arready = 1'b0;
    push(1'b1, 1'b0, 12'd4092, 64'h3004);
    push(1'b1, 1'b0, 12'd32, 64'h6000);
    w = 0;
    @(negedge clk);
    while (!arvalid && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 64'h3800) begin
      n_err++;
      $display("FAIL mid_split: arvalid %b addr %h, need 1 3800", arvalid, araddr);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({arvalid, seg_full, seg_overflow, seg_err, cmd_busy} !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset: valid/full/ovf/err/busy %b, need 00000",
               {arvalid, seg_full, seg_overflow, seg_err, cmd_busy});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    arready = 1'b1;
    ar_before = ar_hs;
    idle_cycles(20);
    n_vec++;
    if (ar_hs !== ar_before || arvalid !== 1'b0 || cmd_busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: %0d commands busy %b, need 0 commands busy 0",
               ar_hs - ar_before, cmd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_split_read();
    test_backpressure();
    test_overflow();
    test_zero_and_invalid();
    test_reset_mid_burst();
    n_vec++;
    if (both_valid !== 0) begin
      n_err++;
      $display("FAIL exclusive_valid: arvalid and awvalid both high %0d cycles, need 0",
               both_valid);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
